// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_if: one REQ/GNT/RVALID bus port (request payload plus response) between a requester and the SRAM arbiter.
// Latency: none, wires only; gnt is returned in the request cycle and rvalid/rdata/err arrive later.
// Backpressure: none; a requester holds req and its payload until it sees gnt.
// Ports: req/we/be/addr/wdata run requester -> arbiter; gnt/rvalid/rdata/err run arbiter -> requester.
interface sram_bus_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: round-robin sharing of one 1024x32 SRAM macro between two REQ/GNT/RVALID bus ports.
// Latency: gnt and SRAM control in the request cycle; rvalid RSP_LAT (1 or 2) cycles after gnt.
// Backpressure: none; the winning request is accepted every cycle and responses return in grant order.
// Ports: clk, rst_n (async, active low); p0 (CPU bus) and p1 (fabric master) as slave modports;
//        sram_addr/bm/din/wen/men/ren drive the macro and sram_dout returns its read data.
module sram_bus_arbiter #(
    parameter int          RSP_LAT   = 1,
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    sram_bus_if.slave   p0,
    sram_bus_if.slave   p1,
    output logic [9:0]  sram_addr,
    output logic [31:0] sram_bm,
    output logic [31:0] sram_din,
    output logic        sram_wen,
    output logic        sram_men,
    output logic        sram_ren,
    input  logic [31:0] sram_dout
);
    typedef struct packed {
        logic vld;
        logic port;
        logic rd;
        logic err;
    } rsp_t;

    logic        last_gnt;
    logic        win1;
    logic        grant;
    logic        access;
    logic        in_win;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [21:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] bm_full;
    logic [31:0] dout_q;
    logic [31:0] rdata_sel;
    logic        rd_ok;
    rsp_t        rsp_in;
    rsp_t        st0;
    rsp_t        st1;
    rsp_t        tail;

    // Port 1 wins when it is the only requester, or on a tie when port 0 was granted last.
    // Everything combinational is gated by rst_n so all outputs sit at 0 while reset is held.
    always_comb begin
        win1      = rst_n & p1.req & (~p0.req | ~last_gnt);
        grant     = rst_n & (p0.req | p1.req);
        sel_we    = win1 ? p1.we           : p0.we;
        sel_be    = win1 ? p1.be           : p0.be;
        sel_addr  = win1 ? p1.addr[23:2]   : p0.addr[23:2];
        sel_wdata = win1 ? p1.wdata        : p0.wdata;
        in_win    = (sel_addr[21:10] == BASE_ADDR[23:12]);
        access    = grant & in_win;
        for (int k = 0; k < 4; k++) begin
            bm_full[8*k +: 8] = {8{sel_be[k]}};
        end
    end

    assign p0.gnt = grant & ~win1;
    assign p1.gnt = win1;

    // Out-of-window requests are granted and answered with err but never touch the macro.
    assign sram_men  = access;
    assign sram_wen  = access & sel_we;
    assign sram_ren  = access & ~sel_we;
    assign sram_addr = access ? sel_addr[9:0] : 10'd0;
    assign sram_bm   = access ? bm_full       : 32'd0;
    assign sram_din  = access ? sel_wdata     : 32'd0;

    assign rsp_in = '{vld: grant, port: win1, rd: ~sel_we, err: ~in_win};

    // st1 and dout_q only reach the outputs when RSP_LAT is 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            st0      <= '0;
            st1      <= '0;
            dout_q   <= '0;
        end else begin
            if (grant) begin
                last_gnt <= win1;
            end
            st0    <= rsp_in;
            st1    <= st0;
            dout_q <= sram_dout;
        end
    end

    assign tail      = (RSP_LAT == 2) ? st1 : st0;
    assign rdata_sel = (RSP_LAT == 2) ? dout_q : sram_dout;
    assign rd_ok     = tail.vld & tail.rd & ~tail.err;

    assign p0.rvalid = tail.vld & ~tail.port;
    assign p1.rvalid = tail.vld & tail.port;
    assign p0.err    = tail.vld & ~tail.port & tail.err;
    assign p1.err    = tail.vld & tail.port & tail.err;
    assign p0.rdata  = (rd_ok & ~tail.port) ? rdata_sel : 32'd0;
    assign p1.rdata  = (rd_ok & tail.port)  ? rdata_sel : 32'd0;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: drives identical traffic into an RSP_LAT=1 and an RSP_LAT=2 arbiter, each with its own SRAM.
// Latency: expectations come from a per-cycle reference (grant rule, word memory, grant-indexed response table).
// Backpressure: requesters hold req and payload until the reference says they were granted.
module tb_sram_bus_arbiter;
    localparam logic [23:0] BASE = 24'h000000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        r_req   [2];
    logic        r_we    [2];
    logic [3:0]  r_be    [2];
    logic [23:0] r_addr  [2];
    logic [31:0] r_wdata [2];

    sram_bus_if b1_0 ();
    sram_bus_if b1_1 ();
    sram_bus_if b2_0 ();
    sram_bus_if b2_1 ();

    assign b1_0.req = r_req[0]; assign b1_0.we = r_we[0]; assign b1_0.be = r_be[0];
    assign b1_0.addr = r_addr[0]; assign b1_0.wdata = r_wdata[0];
    assign b2_0.req = r_req[0]; assign b2_0.we = r_we[0]; assign b2_0.be = r_be[0];
    assign b2_0.addr = r_addr[0]; assign b2_0.wdata = r_wdata[0];
    assign b1_1.req = r_req[1]; assign b1_1.we = r_we[1]; assign b1_1.be = r_be[1];
    assign b1_1.addr = r_addr[1]; assign b1_1.wdata = r_wdata[1];
    assign b2_1.req = r_req[1]; assign b2_1.we = r_we[1]; assign b2_1.be = r_be[1];
    assign b2_1.addr = r_addr[1]; assign b2_1.wdata = r_wdata[1];

    logic [9:0]  s1_addr, s2_addr;
    logic [31:0] s1_bm, s1_din, s1_dout, s2_bm, s2_din, s2_dout;
    logic        s1_wen, s1_men, s1_ren, s2_wen, s2_men, s2_ren;

    sram_bus_arbiter #(.RSP_LAT(1), .BASE_ADDR(BASE)) u_l1 (
        .clk(clk), .rst_n(rst_n), .p0(b1_0), .p1(b1_1),
        .sram_addr(s1_addr), .sram_bm(s1_bm), .sram_din(s1_din),
        .sram_wen(s1_wen), .sram_men(s1_men), .sram_ren(s1_ren), .sram_dout(s1_dout)
    );

    sram_bus_arbiter #(.RSP_LAT(2), .BASE_ADDR(BASE)) u_l2 (
        .clk(clk), .rst_n(rst_n), .p0(b2_0), .p1(b2_1),
        .sram_addr(s2_addr), .sram_bm(s2_bm), .sram_din(s2_din),
        .sram_wen(s2_wen), .sram_men(s2_men), .sram_ren(s2_ren), .sram_dout(s2_dout)
    );

    // Behavioural SRAM macros: sample on the rising edge when MEN is high, clear on the first edge.
    logic        clr_mem;
    logic [31:0] mem1 [1024];
    logic [31:0] mem2 [1024];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= 32'd0;
            s1_dout <= 32'd0;
        end else if (s1_men) begin
            if (s1_wen) mem1[s1_addr] <= (mem1[s1_addr] & ~s1_bm) | (s1_din & s1_bm);
            if (s1_ren) s1_dout <= mem1[s1_addr];
        end
    end

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 1024; i++) mem2[i] <= 32'd0;
            s2_dout <= 32'd0;
        end else if (s2_men) begin
            if (s2_wen) mem2[s2_addr] <= (mem2[s2_addr] & ~s2_bm) | (s2_din & s2_bm);
            if (s2_ren) s2_dout <= mem2[s2_addr];
        end
    end

    // Reference state.
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          m_last = 1;
    int          m_win = -1;
    logic [31:0] gmem  [1024];
    logic        rsp_v [4096];
    logic        rsp_p [4096];
    logic        rsp_e [4096];
    logic [31:0] rsp_d [4096];
    logic        e_g0, e_g1, e_men, e_wen, e_ren;
    logic [9:0]  e_a;
    logic [31:0] e_bm, e_din;
    logic        pend  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    endtask

    task automatic chk_dut(input string n, input int lat,
                           input logic g0, input logic g1, input logic men, input logic wen, input logic ren,
                           input logic [9:0] a, input logic [31:0] bm, input logic [31:0] din,
                           input logic rv0, input logic rv1, input logic [31:0] rd0, input logic [31:0] rd1,
                           input logic er0, input logic er1);
        int g;
        logic ev, ep, ee;
        logic [31:0] ed;
        g  = cyc - lat;
        ev = 1'b0; ep = 1'b0; ee = 1'b0; ed = 32'd0;
        if (g >= 0) begin
            ev = rsp_v[g]; ep = rsp_p[g]; ee = rsp_e[g]; ed = rsp_d[g];
        end
        chk({n, "_gnt0"}, 32'(g0), 32'(e_g0));
        chk({n, "_gnt1"}, 32'(g1), 32'(e_g1));
        chk({n, "_men"},  32'(men), 32'(e_men));
        chk({n, "_wen"},  32'(wen), 32'(e_wen));
        chk({n, "_ren"},  32'(ren), 32'(e_ren));
        chk({n, "_addr"}, 32'(a), 32'(e_a));
        chk({n, "_bm"},   bm, e_bm);
        chk({n, "_din"},  din, e_din);
        chk({n, "_rvalid0"}, 32'(rv0), 32'(ev && !ep));
        chk({n, "_rvalid1"}, 32'(rv1), 32'(ev && ep));
        chk({n, "_err0"},    32'(er0), 32'(ev && !ep && ee));
        chk({n, "_err1"},    32'(er1), 32'(ev && ep && ee));
        chk({n, "_rdata0"},  rd0, (ev && !ep) ? ed : 32'd0);
        chk({n, "_rdata1"},  rd1, (ev && ep) ? ed : 32'd0);
    endtask

    // Move to mid-cycle, work out what this cycle must show, compare both DUTs.
    task automatic eval();
        logic        inw;
        logic [31:0] bmx;
        logic [9:0]  idx;
        #4;
        {e_g0, e_g1, e_men, e_wen, e_ren} = 5'b0;
        e_a = 10'd0; e_bm = 32'd0; e_din = 32'd0;
        m_win = -1;
        if (!rst_n) begin
            m_last = 1;
            if (cyc >= 1) rsp_v[cyc-1] = 1'b0;
            if (cyc >= 2) rsp_v[cyc-2] = 1'b0;
        end else begin
            if (r_req[0] && r_req[1]) m_win = 1 - m_last;
            else if (r_req[0])        m_win = 0;
            else if (r_req[1])        m_win = 1;
            if (m_win >= 0) begin
                m_last = m_win;
                e_g0 = (m_win == 0);
                e_g1 = (m_win == 1);
                inw = (r_addr[m_win][23:12] == BASE[23:12]);
                idx = r_addr[m_win][11:2];
                for (int k = 0; k < 4; k++) bmx[8*k +: 8] = {8{r_be[m_win][k]}};
                rsp_v[cyc] = 1'b1;
                rsp_p[cyc] = (m_win == 1);
                rsp_e[cyc] = !inw;
                rsp_d[cyc] = (inw && !r_we[m_win]) ? gmem[idx] : 32'd0;
                if (inw) begin
                    e_men = 1'b1; e_wen = r_we[m_win]; e_ren = !r_we[m_win];
                    e_a = idx; e_bm = bmx; e_din = r_wdata[m_win];
                    if (r_we[m_win]) gmem[idx] = (gmem[idx] & ~bmx) | (r_wdata[m_win] & bmx);
                end
            end
        end
        chk_dut("L1", 1, b1_0.gnt, b1_1.gnt, s1_men, s1_wen, s1_ren, s1_addr, s1_bm, s1_din,
                b1_0.rvalid, b1_1.rvalid, b1_0.rdata, b1_1.rdata, b1_0.err, b1_1.err);
        chk_dut("L2", 2, b2_0.gnt, b2_1.gnt, s2_men, s2_wen, s2_ren, s2_addr, s2_bm, s2_din,
                b2_0.rvalid, b2_1.rvalid, b2_0.rdata, b2_1.rdata, b2_0.err, b2_1.err);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int p, input logic we, input logic [3:0] be,
                           input logic [23:0] a, input logic [31:0] d);
        r_req[p] = 1'b1; r_we[p] = we; r_be[p] = be; r_addr[p] = a; r_wdata[p] = d;
    endtask

    task automatic idle_all();
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
    endtask

    initial begin
        logic [23:0] a;
        for (int i = 0; i < 1024; i++) gmem[i] = 32'd0;
        for (int i = 0; i < 4096; i++) begin
            rsp_v[i] = 1'b0; rsp_p[i] = 1'b0; rsp_e[i] = 1'b0; rsp_d[i] = 32'd0;
        end
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0; r_we[p] = 1'b0; r_be[p] = 4'h0; r_addr[p] = 24'h0; r_wdata[p] = 32'h0;
            pend[p] = 1'b0;
        end
        rst_n   = 1'b0;
        clr_mem = 1'b1;
        @(posedge clk);
        #1;
        clr_mem = 1'b0;

        // Reset held with both ports requesting: every output must stay 0.
        set_req(0, 1'b0, 4'hF, 24'h000010, 32'h0);
        set_req(1, 1'b0, 4'hF, 24'h000020, 32'h0);
        for (int i = 0; i < 3; i++) begin eval(); adv(); end
        idle_all();
        rst_n = 1'b1;
        eval(); adv();

        // Port 0 write then read back.
        set_req(0, 1'b1, 4'hF, 24'h000010, 32'hDEADBEEF);
        eval();
        chk("wr_gnt0", 32'(b1_0.gnt), 32'd1);
        chk("wr_addr", 32'(s1_addr), 32'd4);
        adv();
        idle_all();
        eval();
        chk("wr_rvalid0", 32'(b1_0.rvalid), 32'd1);
        chk("wr_rdata0", b1_0.rdata, 32'd0);
        adv();
        set_req(0, 1'b0, 4'hF, 24'h000010, 32'h0);
        eval(); adv();
        idle_all();
        eval();
        chk("rd_l1_data", b1_0.rdata, 32'hDEADBEEF);
        chk("rd_l2_early", 32'(b2_0.rvalid), 32'd0);
        adv();
        eval();
        chk("rd_l2_data", b2_0.rdata, 32'hDEADBEEF);
        adv();

        // Byte-mask write from port 1 over 0xAAAAAAAA.
        set_req(1, 1'b1, 4'hF, 24'h000020, 32'hAAAAAAAA);
        eval(); adv();
        set_req(1, 1'b1, 4'b0101, 24'h000022, 32'h11223344);
        eval();
        chk("bm_mask", s1_bm, 32'h00FF00FF);
        adv();
        set_req(1, 1'b0, 4'hF, 24'h000020, 32'h0);
        eval(); adv();
        idle_all();
        eval();
        chk("bm_readback", b1_1.rdata, 32'hAA22AA44);
        adv();
        eval(); adv();

        // Contention: both ports read continuously for 6 cycles.
        set_req(0, 1'b0, 4'hF, 24'h000010, 32'h0);
        set_req(1, 1'b0, 4'hF, 24'h000020, 32'h0);
        for (int i = 0; i < 6; i++) begin
            eval();
            chk("cont_gnt0", 32'(b1_0.gnt), 32'((i % 2) == 0));
            chk("cont_gnt1", 32'(b1_1.gnt), 32'((i % 2) == 1));
            adv();
        end
        idle_all();
        for (int i = 0; i < 2; i++) begin eval(); adv(); end

        // Out-of-window access.
        set_req(0, 1'b0, 4'hF, 24'h001000, 32'h0);
        eval();
        chk("oow_gnt0", 32'(b1_0.gnt), 32'd1);
        chk("oow_men", 32'(s1_men), 32'd0);
        adv();
        idle_all();
        eval();
        chk("oow_err0", 32'(b1_0.err), 32'd1);
        chk("oow_rdata0", b1_0.rdata, 32'd0);
        adv();
        eval(); adv();

        // Back-to-back read stream, latency-2 DUT must give one rvalid per cycle.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_req(0, 1'b0, 4'hF, (i % 2 == 0) ? 24'h000010 : 24'h000020, 32'h0);
            else idle_all();
            eval();
            if (i >= 2) chk("l2_stream_rv", 32'(b2_0.rvalid), 32'd1);
            adv();
        end

        // Reset one cycle after a read grant.
        set_req(0, 1'b0, 4'hF, 24'h000010, 32'h0);
        eval(); adv();
        set_req(1, 1'b0, 4'hF, 24'h000020, 32'h0);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            eval();
            chk("rst_rv_l1", 32'(b1_0.rvalid), 32'd0);
            chk("rst_rv_l2", 32'(b2_0.rvalid), 32'd0);
            chk("rst_gnt0", 32'(b1_0.gnt), 32'd0);
            adv();
        end
        rst_n = 1'b1;
        eval();
        chk("rst_tie_gnt0", 32'(b1_0.gnt), 32'd1);
        adv();
        idle_all();
        for (int i = 0; i < 3; i++) begin eval(); adv(); end

        // Randomized traffic with occasional resets.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(2) != 0) begin
                        a = 24'h0;
                        a[6:2] = 5'($urandom_range(31));
                        a[1:0] = 2'($urandom_range(3));
                        if ($urandom_range(9) == 0) a[23:12] = 12'($urandom_range(4095, 1));
                        set_req(p, 1'($urandom_range(1)),
                                ($urandom_range(7) == 0) ? 4'h0 : 4'($urandom), a, $urandom);
                        pend[p] = 1'b1;
                    end else begin
                        r_req[p] = 1'b0;
                    end
                end
            end
            rst_n = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
            eval();
            if (m_win >= 0) pend[m_win] = 1'b0;
            adv();
        end
        rst_n = 1'b1;
        idle_all();
        for (int i = 0; i < 3; i++) begin eval(); adv(); end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-port arbiter that shares one IHP_SRAM_1024x32 macro between two bus requesters: port 0 is the CPU peripheral bus carried over the CPU_IF tiles, and port 1 is a fabric user master. Both ports use the REQ/GNT/RVALID bus already used by the peripheral bus. The block arbitrates requests round-robin, expands byte enables into the SRAM bit mask, drives MEN/WEN/REN, and returns read data to the owning port through a response pipeline. It sits in user logic between the two bus wrappers and the SRAM wrapper.

## Interface
Parameters:
- RSP_LAT, default 1: request-to-RVALID latency in cycles. Legal values are 1 and 2; 2 adds a register stage on DOUT.
- BASE_ADDR, default 24'h000000: byte base address of the SRAM window (4 KiB, aligned).

Ports (x = 0, 1 for the per-port signals):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_x  in  1  request from port x.
- we_x  in  1  1 = write, 0 = read.
- be_x  in  4  byte enables.
- addr_x  in  24  byte address.
- wdata_x  in  32  write data.
- gnt_x  out  1  request accepted this cycle.
- rvalid_x  out  1  response valid.
- rdata_x  out  32  read data.
- err_x  out  1  response is an error; qualified by rvalid_x.
- sram_addr  out  10  to ADDR.
- sram_bm  out  32  to BM.
- sram_din  out  32  to DIN.
- sram_wen, sram_men, sram_ren  out  1 each  to WEN/MEN/REN.
- sram_dout  in  32  from DOUT.

## Operation
- Arbitration is combinational in the request cycle.
  - If only one req_x is high, that port is granted.
  - If both are high, the port that was not granted most recently wins.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
- Exactly one gnt_x may be high per cycle. gnt_x = req_x AND the port wins arbitration. A request is accepted on every cycle that it wins; there is no backpressure.
- In-window test: addr_x[23:12] == BASE_ADDR[23:12].
- SRAM drive for a granted in-window request:
  - sram_men = 1.
  - sram_ren = !we; sram_wen = we.
  - sram_addr = addr[11:2].
  - sram_bm[8k+7:8k] = {8{be[k]}}.
  - sram_din = wdata.
- SRAM drive when idle, or when the winning request is out-of-window:
  - men, wen and ren are 0.
  - addr, bm and din hold 0.
  - The SRAM is not accessed.
- Response pipeline: RSP_LAT stages, each holding {valid, port, is_read, err}. It is advanced every cycle.
- Response at the end of the pipeline:
  - rvalid of the recorded port = 1 for exactly one cycle.
  - rdata = sram_dout (RSP_LAT=1) or the registered dout (RSP_LAT=2), only for an in-window read. It is 0 for writes and for errors.
  - err = 1 for an out-of-window request; the SRAM is untouched in that case.
- Every write also produces an rvalid, with rdata = 0.
- The non-owning port sees rvalid = 0 and rdata = 0.
- Misaligned addr[1:0] is ignored; addr is word-aligned by truncation. A request with be = 0 still gets a response and writes nothing (bm = 0).

## Timing
- Reset values: all outputs 0. The pipeline is cleared and the last-grant pointer is 1.
- Reset asserted mid-operation discards in-flight responses. No rvalid is issued for them.
- gnt_x is issued in cycle N, the same cycle the SRAM control is driven. The SRAM samples on the rising edge that ends cycle N.
- rvalid_x is issued in cycle N+RSP_LAT.
- Throughput is one access per cycle in total. With both ports requesting continuously, grants alternate 0,1,0,1.
- Responses return strictly in grant order. Back-to-back grants produce back-to-back rvalids.
- A requester must hold req and its payload until gnt. It may drop req the cycle after gnt.
- The arbiter never grants a port that has req low.

## Test plan
- Single write then read, port 0, RSP_LAT=1:
  - Write addr 0x000010, be 4'b1111, wdata 0xDEADBEEF: gnt_0 in the same cycle, sram_addr 4, rvalid_0 next cycle with rdata 0.
  - Read addr 0x000010: rvalid_0 one cycle after gnt, rdata 0xDEADBEEF.
- Byte mask: port 1 writes 0x11223344 with be 4'b0101 over existing 0xAAAAAAAA. sram_bm must be 0x00FF00FF, and a read-back returns 0xAA22AA44.
- Contention: both ports request continuously for 6 cycles. Grants are 0,1,0,1,0,1 and the rvalids follow with the same port order, each delayed by RSP_LAT.
- Out-of-window: port 0 accesses addr 0x001000 with BASE_ADDR 0. gnt_0 is issued with sram_men 0, and rvalid_0 arrives with err_0 = 1 and rdata_0 = 0.
- RSP_LAT=2: a read is granted in cycle N and rvalid appears in cycle N+2 with the correct data. A back-to-back read stream sustains one rvalid per cycle.
- Reset mid-stream: assert rst_n low one cycle after a read grant. No rvalid is issued; all outputs are 0 while rst_n is low; and the first tie after release goes to port 0.
